// File: rtl/vt52_video_pkg.sv
// Shared definitions for the VT52 video output path.
// Cursor mode codes, default geometry and the per-pixel pipeline bundle.
package vt52_video_pkg;

    localparam logic [1:0] CURSOR_OFF   = 2'b00;
    localparam logic [1:0] CURSOR_BLOCK = 2'b01;
    localparam logic [1:0] CURSOR_ULINE = 2'b10;
    localparam logic [1:0] CURSOR_RSVD  = 2'b11;

    localparam int DEF_COL_W  = 6;
    localparam int DEF_ROW_W  = 4;
    localparam int DEF_LINE_W = 4;

    typedef struct packed {
        logic blank;
        logic px;
        logic hs;
        logic vs;
    } pix_t;

    localparam pix_t PIX_RESET = '{blank: 1'b1, px: 1'b0, hs: 1'b0, vs: 1'b0};

endpackage

// File: rtl/video_delay.sv
// Strobe-gated shift register used to keep video aligned with the syncs.
// Every stage clears to RST_VAL asynchronously.
module video_delay #(
    parameter int              WIDTH   = 4,
    parameter int              DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stg [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stg[i] <= RST_VAL;
            end
        end else if (en) begin
            stg[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    assign q = stg[DEPTH-1];

endmodule

// File: rtl/video_compositor.sv
// Composites glyph pixels with a blinking cursor and reverse video,
// delaying video, hsync and vsync by the same number of pixel strobes.
module video_compositor
    import vt52_video_pkg::*;
#(
    parameter int COL_W        = DEF_COL_W,
    parameter int ROW_W        = DEF_ROW_W,
    parameter int LINE_W       = DEF_LINE_W,
    parameter int UL_START     = 14,
    parameter int BLINK_FRAMES = 30,
    parameter int PIPE         = 2,
    parameter bit VIDEO_ON     = 1'b1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              px_en,
    input  logic              hblank,
    input  logic              vblank,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              char_pixel,
    input  logic [COL_W-1:0]  col,
    input  logic [ROW_W-1:0]  row,
    input  logic [LINE_W-1:0] char_line,
    input  logic [COL_W-1:0]  cursor_x,
    input  logic [ROW_W-1:0]  cursor_y,
    input  logic              cursor_moved,
    input  logic [1:0]        cursor_mode,
    input  logic              blink_en,
    input  logic              invert,
    output logic              hsync,
    output logic              vsync,
    output logic              video,
    output logic              blink_on
);

    localparam logic [7:0]        BLINK_LAST = 8'(BLINK_FRAMES - 1);
    localparam logic [LINE_W-1:0] UL_LINE    = LINE_W'(UL_START);

    logic       vblank_q;
    logic [7:0] frm_cnt;
    logic       vb_edge;

    assign vb_edge = vblank & ~vblank_q;

    // A cursor write restarts the blink phase so the cursor shows at once.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            vblank_q <= 1'b0;
            frm_cnt  <= '0;
            blink_on <= 1'b1;
        end else begin
            vblank_q <= vblank;
            if (cursor_moved) begin
                frm_cnt  <= '0;
                blink_on <= 1'b1;
            end else if (vb_edge) begin
                if (frm_cnt == BLINK_LAST) begin
                    frm_cnt  <= '0;
                    blink_on <= ~blink_on;
                end else begin
                    frm_cnt <= frm_cnt + 8'd1;
                end
            end
        end
    end

    logic hit;
    logic shape;
    logic cur;
    pix_t stage_in;
    pix_t stage_out;

    assign hit = (col == cursor_x) & (row == cursor_y);

    always_comb begin
        shape = 1'b0;
        case (cursor_mode)
            CURSOR_OFF:   shape = 1'b0;
            CURSOR_BLOCK: shape = 1'b1;
            CURSOR_ULINE: shape = (char_line >= UL_LINE);
            CURSOR_RSVD:  shape = 1'b1;
        endcase
    end

    assign cur = hit & shape & (blink_on | ~blink_en);

    assign stage_in = '{
        blank: hblank | vblank,
        px:    char_pixel ^ cur ^ invert,
        hs:    hsync_in,
        vs:    vsync_in
    };

    video_delay #(
        .WIDTH  ($bits(pix_t)),
        .DEPTH  (PIPE),
        .RST_VAL(PIX_RESET)
    ) u_delay (
        .clk  (clk),
        .rst_n(clr),
        .en   (px_en),
        .d    (stage_in),
        .q    (stage_out)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            hsync <= 1'b0;
            vsync <= 1'b0;
            video <= ~VIDEO_ON;
        end else if (px_en) begin
            hsync <= stage_out.hs;
            vsync <= stage_out.vs;
            video <= (!stage_out.blank && stage_out.px) ? VIDEO_ON : ~VIDEO_ON;
        end
    end

endmodule
